uart_tx: RTL

//  UART serial transmitter: serialises one DBIT-wide word per request as start bit, data LSB-first,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: frame state encoding (3-bit, common to the
// transmitter and receiver) and oversampling constants.
package uart_pkg;

    // Frame states; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    // Receiver samples each bit at this tick; the transmitter does not need it.
    localparam int MID_BIT    = 7;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity,
// then SB_TICK ticks of stop. Bits are paced by the shared 16x s_tick.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and its flop).
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (low) for 16 ticks
// DATA   | driving shift_reg[0], DBIT bits of 16 ticks each
// PARITY | driving the parity bit for 16 ticks (UART_TX_PARITY_EN only)
// STOP   | line high for SB_TICK ticks, tx_done_tick on the last one
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    // Tick counter must hold SB_TICK-1 and at least 15.
    localparam int TW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);

    // Reject parameter values outside the supported frame formats.
    if (DBIT < 5 || DBIT > 8 || SB_TICK < 1 || SB_TICK > 64 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_param
        $error("uart_tx: unsupported parameter combination");
    end

    uart_state_e     state_reg, state_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [BW-1:0]   bit_reg, bit_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    // State and datapath register; tx is registered from the current state
    // so the pin lags the state by one clk and has no combinational path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state, datapath updates and the done pulse.
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        tx_next      = 1'b1;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                // A tick arriving with the request is not counted.
                if (tx_start) begin
                    shift_next = din;
                    tick_next  = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^din) ^ (PAR_ODD != 0);
`endif
                end
            end
            START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (bit_reg == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_next = bit_reg + BW'(1);
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = parity_reg;
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (tick_reg == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        tick_next    = '0;
                        state_next   = IDLE;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign tx_busy = (state_reg != IDLE);
    assign tx      = tx_reg;

endmodule
